decode_cycle: RTL

DECODE_CYCLE -- requirements
Module: decode_cycle

---
 rtl/decode_cycle.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/decode_cycle.sv
// ID stage: 32x32 register file with write-through, instruction decoder, ID/EX pipeline register.
// Latency: 1 cycle InstrD->E outputs. No backpressure; FlushE loads a bubble.
module decode_cycle (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] InstrD,
    input  logic [31:0] PCD,
    input  logic [31:0] PCPlus4D,
    input  logic        RegWriteW,
    input  logic [4:0]  RDW,
    input  logic [31:0] ResultW,
    input  logic        FlushE,
    output logic        RegWriteE,
    output logic        MemWriteE,
    output logic        JumpE,
    output logic        BranchE,
    output logic        ALUSrcE,
    output logic [1:0]  ResultSrcE,
    output logic [2:0]  ALUControlE,
    output logic [31:0] RD1E,
    output logic [31:0] RD2E,
    output logic [31:0] ImmExtE,
    output logic [31:0] PCE,
    output logic [31:0] PCPlus4E,
    output logic [4:0]  RdE,
    output logic [4:0]  Rs1E,
    output logic [4:0]  Rs2E,
    output logic [4:0]  Rs1D,
    output logic [4:0]  Rs2D
);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef struct packed {
        logic        reg_write;
        logic        mem_write;
        logic        jump;
        logic        branch;
        logic        alu_src;
        logic [1:0]  result_src;
        logic [2:0]  alu_ctrl;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } idex_t;

    logic [31:0][31:0] rf_q, rf_d;
    idex_t             idex_q, idex_d, dec;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rs1, rs2;
    logic        wb_en;
    logic [31:0] rd1_val, rd2_val;
    logic [2:0]  alu_fn;
    logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;

    assign opcode = InstrD[6:0];
    assign funct3 = InstrD[14:12];
    assign rs1    = InstrD[19:15];
    assign rs2    = InstrD[24:20];
    assign Rs1D   = rs1;
    assign Rs2D   = rs2;
    assign wb_en  = RegWriteW && (RDW != 5'd0);

    assign imm_i = {{20{InstrD[31]}}, InstrD[31:20]};
    assign imm_s = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
    assign imm_b = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
    assign imm_j = {{12{InstrD[31]}}, InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
    assign imm_u = {InstrD[31:12], 12'h000};

    // x0 stays zero; a writeback to the address being read bypasses the array.
    always_comb begin
        rf_d = rf_q;
        if (wb_en) begin
            rf_d[RDW] = ResultW;
        end
        rf_d[0] = '0;

        rd1_val = '0;
        if (rs1 != 5'd0) begin
            rd1_val = (wb_en && (RDW == rs1)) ? ResultW : rf_q[rs1];
        end
        rd2_val = '0;
        if (rs2 != 5'd0) begin
            rd2_val = (wb_en && (RDW == rs2)) ? ResultW : rf_q[rs2];
        end
    end

    always_comb begin
        alu_fn = ALU_ADD;
        case (funct3)
            3'b000:  alu_fn = ((opcode == OP_R) && InstrD[30]) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_fn = ALU_SLT;
            3'b110:  alu_fn = ALU_OR;
            3'b111:  alu_fn = ALU_AND;
            default: alu_fn = ALU_ADD;
        endcase
    end

    always_comb begin
        dec     = '0;
        dec.pc  = PCD;
        dec.pc4 = PCPlus4D;
        dec.rd  = InstrD[11:7];
        dec.rs1 = rs1;
        dec.rs2 = rs2;
        dec.rd1 = rd1_val;
        dec.rd2 = rd2_val;
        case (opcode)
            OP_LW: begin
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.result_src = 2'b01;
                dec.imm        = imm_i;
            end
            OP_SW: begin
                dec.mem_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.imm       = imm_s;
            end
            OP_R: begin
                dec.reg_write = 1'b1;
                dec.alu_ctrl  = alu_fn;
            end
            OP_I: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_ctrl  = alu_fn;
                dec.imm       = imm_i;
            end
            OP_BEQ: begin
                dec.branch   = 1'b1;
                dec.alu_ctrl = ALU_SUB;
                dec.imm      = imm_b;
            end
            OP_JAL: begin
                dec.reg_write  = 1'b1;
                dec.jump       = 1'b1;
                dec.result_src = 2'b10;
                dec.imm        = imm_j;
            end
            OP_LUI: begin
                // lui adds the immediate to zero, so operand A is forced to x0.
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.imm       = imm_u;
                dec.rd1       = '0;
                dec.rs1       = '0;
            end
            default: ;
        endcase
        idex_d = FlushE ? '0 : dec;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_q   <= '0;
            idex_q <= '0;
        end else begin
            rf_q   <= rf_d;
            idex_q <= idex_d;
        end
    end

    assign RegWriteE   = idex_q.reg_write;
    assign MemWriteE   = idex_q.mem_write;
    assign JumpE       = idex_q.jump;
    assign BranchE     = idex_q.branch;
    assign ALUSrcE     = idex_q.alu_src;
    assign ResultSrcE  = idex_q.result_src;
    assign ALUControlE = idex_q.alu_ctrl;
    assign RD1E        = idex_q.rd1;
    assign RD2E        = idex_q.rd2;
    assign ImmExtE     = idex_q.imm;
    assign PCE         = idex_q.pc;
    assign PCPlus4E    = idex_q.pc4;
    assign RdE         = idex_q.rd;
    assign Rs1E        = idex_q.rs1;
    assign Rs2E        = idex_q.rs2;

endmodule
